// File: rtl/matrix_memory_if.sv
// Request/response bus for matrix_memory: row requests in, one ordered response per request out.
interface matrix_memory_if #(
   parameter int DATA_W = 256,
   parameter int ELEM_W = 16,
   parameter int ADDR_W = 8
);
   localparam int LANES = DATA_W / ELEM_W;

   logic              clr_start;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [LANES-1:0]  req_lane_en;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output clr_start, req_valid, req_write, req_addr, req_wdata, req_lane_en, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  clr_start, req_valid, req_write, req_addr, req_wdata, req_lane_en, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/matrix_memory.sv
// Row-addressed memory with per-lane write enables, a one-deep response register
// and a row-by-row clear sequence that runs after reset or on request.
module matrix_memory #(
   parameter int DATA_W = 256,
   parameter int ELEM_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 8
) (
   input logic            clk,
   input logic            Reset,
   matrix_memory_if.slave bus
);
   localparam int LANES = DATA_W / ELEM_W;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DEPTH - 1);

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t            state;
   logic [IDX_W-1:0]  clrPtr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              vld_p1;
   logic              err_p1;
   logic [DATA_W-1:0] rdata_p1;

   logic              reqReady;
   logic              accept;
   logic              addrOk;
   logic [IDX_W-1:0]  idx;

   assign addrOk   = ({1'b0, bus.req_addr} < DEPTH_V);
   assign idx      = bus.req_addr[IDX_W-1:0];
   assign reqReady = (state == READY) && (!vld_p1 || bus.rsp_ready);
   // A clear request wins over a request on the same edge.
   assign accept   = bus.req_valid && reqReady && !bus.clr_start;

   assign bus.req_ready = reqReady;
   assign bus.busy      = (state == CLEAR);
   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_rdata = rdata_p1;
   assign bus.rsp_err   = err_p1;

   always_ff @(posedge clk) begin
      if (Reset) begin
         state  <= CLEAR;
         clrPtr <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (clrPtr == LAST_ROW) begin
                  state  <= READY;
                  clrPtr <= '0;
               end else begin
                  clrPtr <= clrPtr + 1'b1;
               end
            end
            READY: begin
               if (bus.clr_start) state <= CLEAR;
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // Stage p1: response register, holds until consumed or replaced
   always_ff @(posedge clk) begin
      if (Reset) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         rdata_p1 <= '0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         err_p1   <= !addrOk;
         rdata_p1 <= (!bus.req_write && addrOk) ? mem[idx] : '0;
      end else if (bus.rsp_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         if (state == CLEAR) begin
            mem[clrPtr] <= '0;
         end else if (accept && bus.req_write && addrOk) begin
            for (int i = 0; i < LANES; i++) begin
               if (bus.req_lane_en[i]) mem[idx][i*ELEM_W +: ELEM_W] <= bus.req_wdata[i*ELEM_W +: ELEM_W];
            end
         end
      end
   end
endmodule

// File: tb/tb_matrix_memory.sv
// Directed bench for matrix_memory: runs the same suite on a 256b/16-lane/8-row
// instance and a 64b/8-lane/32-row instance.
module tb_matrix_memory;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   bit           sel = 1'b0;
   logic         clrStart = 1'b0;
   logic         valid = 1'b0;
   logic         write = 1'b0;
   logic [7:0]   addr = '0;
   logic [255:0] wdata = '0;
   logic [15:0]  laneEn = '0;
   logic         rspReady = 1'b1;
   int           checks = 0;
   int           errors = 0;

   logic         rdy, vld, err, bsy;
   logic [255:0] rdata;

   matrix_memory_if #(.DATA_W(256), .ELEM_W(16), .ADDR_W(8)) ifA ();
   matrix_memory_if #(.DATA_W(64),  .ELEM_W(8),  .ADDR_W(8)) ifB ();

   matrix_memory #(.DATA_W(256), .ELEM_W(16), .DEPTH(8), .ADDR_W(8))
      dutA (.clk(clk), .Reset(rst), .bus(ifA.slave));
   matrix_memory #(.DATA_W(64), .ELEM_W(8), .DEPTH(32), .ADDR_W(8))
      dutB (.clk(clk), .Reset(rst), .bus(ifB.slave));

   always #5 clk = ~clk;

   assign ifA.clr_start   = clrStart && !sel;
   assign ifA.req_valid   = valid && !sel;
   assign ifA.req_write   = write;
   assign ifA.req_addr    = addr;
   assign ifA.req_wdata   = wdata;
   assign ifA.req_lane_en = laneEn;
   assign ifA.rsp_ready   = rspReady;

   assign ifB.clr_start   = clrStart && sel;
   assign ifB.req_valid   = valid && sel;
   assign ifB.req_write   = write;
   assign ifB.req_addr    = addr;
   assign ifB.req_wdata   = wdata[63:0];
   assign ifB.req_lane_en = laneEn[7:0];
   assign ifB.rsp_ready   = rspReady;

   assign rdy   = sel ? ifB.req_ready : ifA.req_ready;
   assign vld   = sel ? ifB.rsp_valid : ifA.rsp_valid;
   assign err   = sel ? ifB.rsp_err   : ifA.rsp_err;
   assign bsy   = sel ? ifB.busy      : ifA.busy;
   assign rdata = sel ? {192'b0, ifB.rsp_rdata} : ifA.rsp_rdata;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cfg=%0d got=%h exp=%h", tag, sel, got, exp);
      end
   endtask

   // Entered at a point just after a rising edge; leaves just after one with busy low.
   task automatic waitClear(input bit afterReset, input int depth);
      int cnt = 0;
      @(negedge clk);
      if (afterReset) begin
         chk("rstBusy", bsy, 1'b1);
         chk("rstRdy", rdy, 1'b0);
         chk("rstVld", vld, 1'b0);
      end
      while (bsy && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      chk("clrLen", cnt, depth);
      chk("rdyAfterClr", rdy, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic doReq(input bit wr, input logic [7:0] a, input logic [255:0] d,
                        input logic [15:0] en, output logic [255:0] gotD, output logic gotE);
      int n = 0;
      valid = 1'b1; write = wr; addr = a; wdata = d; laneEn = en; rspReady = 1'b1;
      @(negedge clk);
      while (!rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("accept", (n < 50), 1'b1);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      chk("rspLatency", vld, 1'b1);
      gotD = rdata;
      gotE = err;
      @(posedge clk);
      #1;
   endtask

   task automatic readChk(input string tag, input logic [7:0] a, input logic [255:0] expD, input logic expE);
      logic [255:0] d;
      logic         e;
      doReq(1'b0, a, '0, '0, d, e);
      chk(tag, d, expD);
      chk({tag, "Err"}, e, expE);
   endtask

   task automatic writeChk(input logic [7:0] a, input logic [255:0] d, input logic [15:0] en, input logic expE);
      logic [255:0] gd;
      logic         ge;
      doReq(1'b1, a, d, en, gd, ge);
      chk("wrRspData", gd, '0);
      chk("wrRspErr", ge, expE);
   endtask

   task automatic runSuite(input bit s);
      logic [255:0] w1, w2, row3, fill;
      logic [15:0]  enAll, enHalf;
      int           depth;
      sel   = s;
      depth = s ? 32 : 8;
      if (!s) begin
         w1 = {16{16'hABCD}}; w2 = {16{16'h1234}};
         enAll = 16'hFFFF; enHalf = 16'h00FF;
         row3 = {{8{16'hABCD}}, {8{16'h1234}}};
         fill = {16{16'h5AA5}};
      end else begin
         w1 = {32{8'hAB}}; w2 = {32{8'h34}};
         enAll = 16'h00FF; enHalf = 16'h000F;
         row3 = {192'b0, {4{8'hAB}}, {4{8'h34}}};
         fill = {192'b0, {8{8'h5A}}};
      end

      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      waitClear(1'b1, depth);
      for (int a = 0; a < depth; a++) readChk("rdInit", 8'(a), '0, 1'b0);

      writeChk(8'd3, w1, enAll, 1'b0);
      writeChk(8'd3, w2, enHalf, 1'b0);
      readChk("rdMerge", 8'd3, row3, 1'b0);

      readChk("rdOob", 8'(depth + 1), '0, 1'b1);
      writeChk(8'd200, w1, enAll, 1'b1);
      for (int a = 0; a < depth; a++) readChk("rdKeep", 8'(a), (a == 3) ? row3 : '0, 1'b0);

      // Stalled response must hold and block new requests
      valid = 1'b1; write = 1'b0; addr = 8'd3; rspReady = 1'b0;
      @(posedge clk);
      #1 valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stallVld", vld, 1'b1);
         chk("stallData", rdata, row3);
         chk("stallRdy", rdy, 1'b0);
      end
      @(posedge clk);
      #1 rspReady = 1'b1; valid = 1'b1; addr = 8'd0;
      @(negedge clk);
      chk("b2bRdy", rdy, 1'b1);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      chk("b2bVld", vld, 1'b1);
      chk("b2bData", rdata, '0);
      @(posedge clk);
      #1;

      for (int a = 0; a < depth; a++) writeChk(8'(a), fill, enAll, 1'b0);
      readChk("rdFill", 8'(depth - 1), fill, 1'b0);
      clrStart = 1'b1;
      @(posedge clk);
      #1 clrStart = 1'b0;
      waitClear(1'b0, depth);
      for (int a = 0; a < depth; a++) readChk("rdCleared", 8'(a), '0, 1'b0);

      // Reset in the middle of a clear restarts it from row 0
      writeChk(8'd5, fill, enAll, 1'b0);
      clrStart = 1'b1;
      @(posedge clk);
      #1 clrStart = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      waitClear(1'b1, depth);
      readChk("rdAfterRst", 8'd5, '0, 1'b0);
   endtask

   initial begin
      runSuite(1'b0);
      runSuite(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cfg=%0d got=timeout exp=finish", sel);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/matrix_memory.md
MATRIX_MEMORY -- requirements
Module: matrix_memory

Interface
REQ-001 SHALL provide parameters: DATA_W, default 256, row width in bits; ELEM_W, default 16, element (lane) width; DEPTH, default 8, number of rows; ADDR_W, default 8, address width. LANES = DATA_W/ELEM_W; DATA_W SHALL be a multiple of ELEM_W and DEPTH SHALL be at most 2^ADDR_W.
REQ-002 SHALL provide ports:
  clk  in  1  clock; all state changes on rising edge
  Reset  in  1  synchronous, active-high reset
  clr_start  in  1  pulse; request full-array clear
  req_valid  in  1  request present
  req_ready  out  1  request accepted when req_valid && req_ready at an edge
  req_write  in  1  1 = write, 0 = read
  req_addr  in  ADDR_W  row address
  req_wdata  in  DATA_W  write data
  req_lane_en  in  LANES  per-lane write enable; bit i covers bits [i*ELEM_W +: ELEM_W]
  rsp_valid  out  1  response present
  rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge
  rsp_rdata  out  DATA_W  read data; zero for write responses
  rsp_err  out  1  address >= DEPTH
  busy  out  1  clear sequence in progress

Function
REQ-003 SHALL implement FSM states CLEAR and READY only.
REQ-004 In CLEAR, SHALL write all-zero to row clr_ptr each cycle, incrementing clr_ptr from 0; after row DEPTH-1 is written, SHALL enter READY on the next edge and hold clr_ptr at 0.
REQ-005 busy SHALL be 1 exactly while in CLEAR; a full clear SHALL take DEPTH cycles.
REQ-006 req_ready SHALL be 1 iff state is READY and (rsp_valid is 0 or rsp_ready is 1); req_ready SHALL NOT depend on req_valid.
REQ-007 An accepted write to an address < DEPTH SHALL update only the lanes with req_lane_en set, at the acceptance edge.
REQ-008 An accepted read SHALL present row data on rsp_rdata with rsp_valid=1 in the cycle after acceptance, for a latency of 1.
REQ-009 Every accepted request SHALL produce exactly one response, and responses SHALL be returned in acceptance order. A write response SHALL have rsp_rdata=0.
REQ-010 An accepted request with address >= DEPTH SHALL leave memory unchanged and SHALL respond with rsp_err=1 and rsp_rdata=0; otherwise rsp_err SHALL be 0.
REQ-011 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-012 When a response is consumed and a new request is accepted on the same edge, the new response SHALL replace the old one, with no bubble.
REQ-013 A read accepted in the cycle after a write to the same address SHALL return the post-write data.
REQ-014 clr_start SHALL be sampled only in READY. If clr_start is asserted in READY, the block SHALL enter CLEAR on that edge and SHALL not accept a request on that edge, so req_ready is effectively 0. A pending response SHALL remain valid until consumed.
REQ-015 clr_start asserted during CLEAR SHALL be ignored.

Reset
REQ-016 Reset SHALL set the state to CLEAR, clr_ptr=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0. Outputs SHALL read busy=1 and req_ready=0 in the first cycle after reset.
REQ-017 Reset SHALL take priority over all other inputs. A Reset asserted mid-clear or mid-transaction SHALL discard any pending response and restart the clear from row 0.
REQ-018 Memory contents SHALL become all-zero only through the CLEAR sequence; there SHALL be no asynchronous clear.

Verification
REQ-019 Reset for 1 cycle, then release -> busy=1 for exactly 8 cycles, then req_ready=1; a read of every address 0..7 returns 0 with rsp_err=0.
REQ-020 Write addr 3, data all 0xABCD lanes, lane_en=0xFFFF; then write addr 3, data all 0x1234, lane_en=0x00FF; then read addr 3 -> lanes 0-7 = 0x1234, lanes 8-15 = 0xABCD, one cycle after acceptance.
REQ-021 Read addr 9 with DEPTH=8 -> rsp_err=1, rsp_rdata=0. Write addr 200 -> rsp_err=1, and a subsequent read of all rows shows them unchanged.
REQ-022 Hold rsp_ready=0 for 5 cycles after a read response -> req_ready=0 and the response is stable for all 5 cycles. Then rsp_ready=1 with a back-to-back read -> the next response appears on the following cycle.
REQ-023 Fill rows with nonzero data, pulse clr_start -> busy=1 for 8 cycles and all rows then read 0. Assert Reset at clear cycle 4 -> the clear restarts and busy lasts 8 cycles from the release of Reset.
REQ-024 Repeat REQ-019 through REQ-022 with DATA_W=64, ELEM_W=8 and DEPTH=32 -> same behaviour, with 32-cycle clears and 8 lanes.
